joypad_port: RTL and testbench

Bus-side responder for the two standard controller ports on the 2A03 CPU. It decodes the CPU's `addr4016w` / `naddr4016r` / `naddr4017r` strobes and holds the controller strobe latch. It emulates two 8-bit parallel-in/serial-out button shift registers and drives the serial bit back onto the CPU data bus during reads of $4016/$4017. It sits beside `cpu_2a03` at top level, between the CPU bus and the physical button inputs.

---
 rtl/joypad_pkg.sv | 25 ++
 rtl/joypad_if.sv | 39 +++
 rtl/joypad_shifter.sv | 71 +++++++
 rtl/joypad_port.sv | 65 ++++++
 tb/tb_joypad_port.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/joypad_pkg.sv
// ---------------------------------------------------------------------------
// joypad_pkg
// Shared constants for the 2A03 controller port responder.
//   BTN_A .. BTN_RIGHT : bit positions of each button in a port's button word
//   OPEN_BUS           : value returned on data_out[7:1] during a port read
//   SHIFT_FILL         : bit shifted into bit 7 on each read, so an exhausted
//                        port reads back as 1
// Optional build macro used by the files importing this package:
//   JOYPAD_SYNC_EN     : add two-flop button synchronisers
// ---------------------------------------------------------------------------
package joypad_pkg;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam logic [7:0] OPEN_BUS   = 8'h40;
    localparam logic       SHIFT_FILL = 1'b1;

endpackage

// File: rtl/joypad_if.sv
// ---------------------------------------------------------------------------
// joypad_if
// CPU-side bus between the 2A03 core and the controller port responder.
//   addr4016w  : CPU -> port, high for one write cycle to $4016
//   naddr4016r : CPU -> port, low while $4016 (port 0) is being read
//   naddr4017r : CPU -> port, low while $4017 (port 1) is being read
//   data_in    : CPU -> port, write data (only bit 0 is meaningful)
//   data_out   : port -> CPU, read data
//   data_oe    : port -> CPU, high when data_out must drive the bus
// Modports: master (CPU side), slave (joypad_port side).
// ---------------------------------------------------------------------------
interface joypad_if;

    logic       addr4016w;
    logic       naddr4016r;
    logic       naddr4017r;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output addr4016w,
        output naddr4016r,
        output naddr4017r,
        output data_in,
        input  data_out,
        input  data_oe
    );

    modport slave (
        input  addr4016w,
        input  naddr4016r,
        input  naddr4017r,
        input  data_in,
        output data_out,
        output data_oe
    );

endinterface

// File: rtl/joypad_shifter.sv
// ---------------------------------------------------------------------------
// joypad_shifter
// One controller's 8-bit parallel-in/serial-out button shift register.
//   clock   : system clock, rising edge
//   nreset  : asynchronous active-low reset
//   strobe  : controller strobe latch (1 = continuously reload from buttons)
//   nread   : active-low read strobe for this port
//   buttons : raw button inputs, active high
//   q       : serial bit presented to the CPU
// Build macro JOYPAD_SYNC_EN: when defined, buttons pass through a two-flop
// synchroniser and every internal use takes the synchronised copy.
// ---------------------------------------------------------------------------
module joypad_shifter
    import joypad_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic       strobe,
    input  logic       nread,
    input  logic [7:0] buttons,
    output logic       q
);

    logic [7:0] w_btn;
    logic [7:0] r_shift;
    logic       r_prev;
    logic       w_readEnd;

`ifdef JOYPAD_SYNC_EN
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn = r_sync2;
`else
    assign w_btn = buttons;
`endif

    // A read ends when the active-low strobe rises; this fires once per read
    // no matter how long the strobe was held low.
    assign w_readEnd = ~r_prev & nread;

    // strobe is the registered latch value, so on a cycle that also carries a
    // $4016 write this still sees the pre-write strobe.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_prev  <= 1'b1;
            r_shift <= 8'hFF;
        end else begin
            r_prev <= nread;
            if (strobe) begin
                r_shift <= w_btn;
            end else if (w_readEnd) begin
                r_shift <= {SHIFT_FILL, r_shift[7:1]};
            end
        end
    end

    // While strobing, the CPU sees the live A button rather than the register.
    assign q = strobe ? w_btn[BTN_A] : r_shift[0];

endmodule

// File: rtl/joypad_port.sv
// ---------------------------------------------------------------------------
// joypad_port
// Bus-side responder for the two controller ports ($4016/$4017).
//   clock    : system clock, rising edge
//   nreset   : asynchronous active-low reset
//   buttons0 : port 0 buttons, active high (A,B,Select,Start,Up,Down,Left,Right)
//   buttons1 : port 1 buttons, same order
//   bus      : joypad_if.slave - CPU strobes, write data, read data and enable
// Holds the strobe latch, one joypad_shifter per port, and the read mux.
// Build macro JOYPAD_SYNC_EN: enables button synchronisers in the shifters.
// ---------------------------------------------------------------------------
module joypad_port
    import joypad_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic [7:0] buttons0,
    input  logic [7:0] buttons1,
    joypad_if.slave    bus
);

    logic r_strobe;
    logic w_q0;
    logic w_q1;

    // Controller strobe latch; only bit 0 of the write data is meaningful.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_strobe <= 1'b0;
        end else if (bus.addr4016w) begin
            r_strobe <= bus.data_in[0];
        end
    end

    joypad_shifter u_port0 (
        .clock   (clock),
        .nreset  (nreset),
        .strobe  (r_strobe),
        .nread   (bus.naddr4016r),
        .buttons (buttons0),
        .q       (w_q0)
    );

    joypad_shifter u_port1 (
        .clock   (clock),
        .nreset  (nreset),
        .strobe  (r_strobe),
        .nread   (bus.naddr4017r),
        .buttons (buttons1),
        .q       (w_q1)
    );

    assign bus.data_oe = ~bus.naddr4016r | ~bus.naddr4017r;

    // Port 0 wins if both reads are (illegally) active together.
    always_comb begin
        bus.data_out = 8'h00;
        if (!bus.naddr4016r) begin
            bus.data_out = {OPEN_BUS[7:1], w_q0};
        end else if (!bus.naddr4017r) begin
            bus.data_out = {OPEN_BUS[7:1], w_q1};
        end
    end

endmodule

// File: tb/tb_joypad_port.sv
// ---------------------------------------------------------------------------
// tb_joypad_port
// Directed stimulus for joypad_port. Each read pushes its hand-computed bus
// value (once per low cycle) into a queue; an independent monitor pops and
// compares on every falling clock edge where data_oe is high.
// ---------------------------------------------------------------------------
module tb_joypad_port;
    import joypad_pkg::*;

    typedef struct {
        logic [7:0] data;
        string      name;
    } exp_t;

    logic       clock;
    logic       nreset;
    logic [7:0] buttons0;
    logic [7:0] buttons1;

    exp_t expQ[$];
    int   checks;
    int   passes;

    joypad_if bus ();

    joypad_port dut (
        .clock    (clock),
        .nreset   (nreset),
        .buttons0 (buttons0),
        .buttons1 (buttons1),
        .bus      (bus)
    );

    // 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point shared by stimulus-side and monitor-side checks
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual === expected) begin
            passes = passes + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every driven bus cycle must match the next queued expectation
    always @(negedge clock) begin
        if (nreset && bus.data_oe) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRead", {24'h0, bus.data_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput(e.name, {24'h0, bus.data_out}, {24'h0, e.data});
            end
        end
    end

    // port: 0 = $4016, 1 = $4017, 2 = both strobes low together
    task automatic readPort(input int port, input logic bitExp, input int cycles,
                            input string name);
        exp_t e;
        @(posedge clock);
        #1;
        e.data = {OPEN_BUS[7:1], bitExp};
        e.name = name;
        for (int i = 0; i < cycles; i++) expQ.push_back(e);
        if (port != 1) bus.naddr4016r = 1'b0;
        if (port != 0) bus.naddr4017r = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        bus.naddr4016r = 1'b1;
        bus.naddr4017r = 1'b1;
        #1;
        checkOutput({name, "_oeOff"}, {31'h0, bus.data_oe}, 32'h0);
    endtask

    // Write to $4016 with junk in the unused upper bits, then let any
    // synchroniser settle.
    task automatic writeStrobe(input logic v);
        @(posedge clock);
        #1;
        bus.addr4016w = 1'b1;
        bus.data_in   = {7'h55, v};
        @(posedge clock);
        #1;
        bus.addr4016w = 1'b0;
        bus.data_in   = 8'h00;
        repeat (3) @(posedge clock);
    endtask

    task automatic latchButtons(input logic [7:0] b0, input logic [7:0] b1);
        buttons0 = b0;
        buttons1 = b1;
        writeStrobe(1'b1);
        writeStrobe(1'b0);
    endtask

    task automatic applyStimulus();
        logic [9:0] seq;

        // Reset state
        #1;
        checkOutput("resetOe", {31'h0, bus.data_oe}, 32'h0);
        checkOutput("resetData", {24'h0, bus.data_out}, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;

        // Unstrobed reads return the 1-filled register
        for (int i = 0; i < 3; i++) readPort(0, 1'b1, 1, "resetRead");

        // Serial sequence from buttons0 = 1000_0101, then 1s after 8 shifts
        latchButtons(8'b1000_0101, 8'h00);
        seq = 10'b11_1000_0101;
        for (int i = 0; i < 10; i++) readPort(0, seq[i], 1, "serialSeq");

        // Strobe held high: reads follow the live A button
        buttons0 = 8'b1000_0101;
        writeStrobe(1'b1);
        readPort(0, 1'b1, 1, "liveA1");
        buttons0[BTN_A] = 1'b0;
        repeat (3) @(posedge clock);
        readPort(0, 1'b0, 1, "liveA0");
        buttons0[BTN_A] = 1'b1;
        repeat (3) @(posedge clock);
        readPort(0, 1'b1, 1, "liveA1b");
        writeStrobe(1'b0);
        readPort(0, 1'b1, 1, "afterLive0");
        readPort(0, 1'b0, 1, "afterLive1");
        readPort(0, 1'b1, 1, "afterLive2");

        // Long read: stable data, exactly one shift afterwards
        latchButtons(8'b0000_0010, 8'h00);
        readPort(0, 1'b0, 5, "longRead");
        readPort(0, 1'b1, 1, "afterLong1");
        readPort(0, 1'b0, 1, "afterLong2");

        // Independent ports
        latchButtons(8'h00, 8'hFF);
        readPort(0, 1'b0, 1, "indep4016a");
        readPort(1, 1'b1, 1, "indep4017");
        readPort(0, 1'b0, 1, "indep4016b");
        latchButtons(8'b0000_0010, 8'b0000_0110);
        readPort(1, 1'b0, 1, "p1bit0");
        readPort(0, 1'b0, 1, "p0bit0");
        readPort(0, 1'b1, 1, "p0bit1");
        readPort(1, 1'b1, 1, "p1bit1");
        readPort(1, 1'b1, 1, "p1bit2");
        readPort(1, 1'b0, 1, "p1bit3");

        // Both strobes low: port 0 data driven, both ports shift
        latchButtons(8'b0000_0011, 8'b0000_0010);
        readPort(2, 1'b1, 1, "bothRead");
        readPort(0, 1'b1, 1, "bothAfterP0");
        readPort(1, 1'b1, 1, "bothAfterP1");

        // Read-end on the same edge as a write of 0 while strobe was 1:
        // the register reloads rather than shifts
        buttons0 = 8'b0000_0010;
        writeStrobe(1'b1);
        begin
            exp_t e;
            @(posedge clock);
            #1;
            e.data = 8'h40;
            e.name = "rdWrLive";
            expQ.push_back(e);
            bus.naddr4016r = 1'b0;
            @(posedge clock);
            #1;
            bus.naddr4016r = 1'b1;
            bus.addr4016w  = 1'b1;
            bus.data_in    = 8'h00;
            @(posedge clock);
            #1;
            bus.addr4016w  = 1'b0;
        end
        readPort(0, 1'b0, 1, "rdWrBit0");
        readPort(0, 1'b1, 1, "rdWrBit1");
        readPort(0, 1'b0, 1, "rdWrBit2");

        // Asynchronous reset mid-sequence
        latchButtons(8'h00, 8'h00);
        for (int i = 0; i < 3; i++) readPort(0, 1'b0, 1, "preReset");
        nreset = 1'b0;
        #2;
        checkOutput("midResetOe", {31'h0, bus.data_oe}, 32'h0);
        nreset = 1'b1;
        readPort(0, 1'b1, 1, "postReset");

`ifdef JOYPAD_SYNC_EN
        // A button change right before strobe falls is not yet synchronised
        buttons0 = 8'h01;
        writeStrobe(1'b1);
        @(posedge clock);
        #1;
        buttons0      = 8'h00;
        bus.addr4016w = 1'b1;
        bus.data_in   = 8'h00;
        @(posedge clock);
        #1;
        bus.addr4016w = 1'b0;
        readPort(0, 1'b1, 1, "syncLate");
`endif
    endtask

    initial begin
        checks         = 0;
        passes         = 0;
        nreset         = 1'b0;
        buttons0       = 8'h00;
        buttons1       = 8'h00;
        bus.addr4016w  = 1'b0;
        bus.naddr4016r = 1'b1;
        bus.naddr4017r = 1'b1;
        bus.data_in    = 8'h00;

        applyStimulus();

        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clock);
        checkOutput("queueDrained", expQ.size(), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
